// File: rtl/ex_pkg.sv
// Shared EX-stage definitions: ALU opcodes, forward-select codes, control bundle
// and the forwarding helper functions used by ex_mem_reg.
package ex_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SLL = 4'b0100;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_WB    = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;

    typedef struct packed {
        logic branch;
        logic memwrite;
        logic memread;
        logic memtoreg;
        logic regwrite;
    } ctrl_t;

    // EX/MEM wins over MEM/WB; x0 is hard-wired zero and never forwarded.
    function automatic logic [1:0] fwd_select(input logic [4:0] rs,
                                              input logic       exmem_rw,
                                              input logic [4:0] exmem_rd,
                                              input logic       memwb_rw,
                                              input logic [4:0] memwb_rd);
        logic [1:0] sel;
        sel = FWD_REG;
        if (exmem_rw && (exmem_rd != 5'd0) && (exmem_rd == rs))
            sel = FWD_EXMEM;
        else if (memwb_rw && (memwb_rd != 5'd0) && (memwb_rd == rs))
            sel = FWD_WB;
        return sel;
    endfunction

    function automatic logic [63:0] fwd_mux(input logic [1:0]  sel,
                                            input logic [63:0] reg_val,
                                            input logic [63:0] wb_val,
                                            input logic [63:0] exmem_val);
        logic [63:0] val;
        case (sel)
            FWD_WB:    val = wb_val;
            FWD_EXMEM: val = exmem_val;
            default:   val = reg_val;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/ex_mem_reg_if.sv
// Signal bundle around the EX stage / EX-MEM register; master drives the stage
// inputs and observes its outputs, slave is the stage-side view.
interface ex_mem_reg_if;
    logic        flush;
    logic [3:0]  alu_control_signal;
    logic [63:0] pc_in;
    logic [63:0] imm_in;
    logic        alusrc_in;
    logic [4:0]  rs1_in;
    logic [4:0]  rs2_in;
    logic [63:0] rd1_in;
    logic [63:0] rd2_in;
    logic [4:0]  write_reg_in;
    logic        branch_in;
    logic        memwrite_in;
    logic        memread_in;
    logic        memtoreg_in;
    logic        regwrite_in;
    logic [4:0]  mem_wb_rd;
    logic        mem_wb_regwrite;
    logic [63:0] wb_data;
    logic [63:0] pc_out;
    logic        zero_out;
    logic [63:0] alu_result_out;
    logic [63:0] read_data2_out;
    logic [4:0]  write_reg_out;
    logic        branch_out;
    logic        memwrite_out;
    logic        memread_out;
    logic        memtoreg_out;
    logic        regwrite_out;
    logic [1:0]  forward_a;
    logic [1:0]  forward_b;

    modport master (
        output flush, alu_control_signal, pc_in, imm_in, alusrc_in, rs1_in, rs2_in,
               rd1_in, rd2_in, write_reg_in, branch_in, memwrite_in, memread_in,
               memtoreg_in, regwrite_in, mem_wb_rd, mem_wb_regwrite, wb_data,
        input  pc_out, zero_out, alu_result_out, read_data2_out, write_reg_out,
               branch_out, memwrite_out, memread_out, memtoreg_out, regwrite_out,
               forward_a, forward_b
    );

    modport slave (
        input  flush, alu_control_signal, pc_in, imm_in, alusrc_in, rs1_in, rs2_in,
               rd1_in, rd2_in, write_reg_in, branch_in, memwrite_in, memread_in,
               memtoreg_in, regwrite_in, mem_wb_rd, mem_wb_regwrite, wb_data,
        output pc_out, zero_out, alu_result_out, read_data2_out, write_reg_out,
               branch_out, memwrite_out, memread_out, memtoreg_out, regwrite_out,
               forward_a, forward_b
    );
endinterface

// File: rtl/alu_core.sv
// Combinational 64-bit ALU with zero flag; unknown opcodes yield 0.
module alu_core
    import ex_pkg::*;
(
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic [3:0]  op,
    output logic [63:0] result,
    output logic        zero
);
    always_comb begin
        result = '0;
        case (op)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_ADD: result = a + b;
            ALU_XOR: result = a ^ b;
            ALU_SLL: result = a << b[5:0];
            ALU_SRL: result = a >> b[5:0];
            ALU_SUB: result = a - b;
            ALU_SLT: result = {63'd0, ($signed(a) < $signed(b))};
            default: result = '0;
        endcase
    end

    assign zero = (result == 64'd0);
endmodule

// File: rtl/ex_mem_reg.sv
// EX stage with operand forwarding feeding the EX/MEM pipeline register.
// Define EX_FORWARDING_EN to enable forwarding; otherwise operands come from rd1/rd2.
module ex_mem_reg
    import ex_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [3:0]  alu_control_signal,
    input  logic [63:0] pc_in,
    input  logic [63:0] imm_in,
    input  logic        alusrc_in,
    input  logic [4:0]  rs1_in,
    input  logic [4:0]  rs2_in,
    input  logic [63:0] rd1_in,
    input  logic [63:0] rd2_in,
    input  logic [4:0]  write_reg_in,
    input  logic        branch_in,
    input  logic        memwrite_in,
    input  logic        memread_in,
    input  logic        memtoreg_in,
    input  logic        regwrite_in,
    input  logic [4:0]  mem_wb_rd,
    input  logic        mem_wb_regwrite,
    input  logic [63:0] wb_data,
    output logic [63:0] pc_out,
    output logic        zero_out,
    output logic [63:0] alu_result_out,
    output logic [63:0] read_data2_out,
    output logic [4:0]  write_reg_out,
    output logic        branch_out,
    output logic        memwrite_out,
    output logic        memread_out,
    output logic        memtoreg_out,
    output logic        regwrite_out,
    output logic [1:0]  forward_a,
    output logic [1:0]  forward_b
);
    ctrl_t       ctrl_d, ctrl_q;
    logic [63:0] pc_d, pc_q;
    logic [63:0] alu_res_d, alu_res_q;
    logic [63:0] rd2_d, rd2_q;
    logic [4:0]  wr_q;
    logic        zero_d, zero_q;
    logic [63:0] op_a, op_b;

`ifdef EX_FORWARDING_EN
    // Selects look at the register contents before the edge (previous instruction).
    assign forward_a = fwd_select(rs1_in, ctrl_q.regwrite, wr_q, mem_wb_regwrite, mem_wb_rd);
    assign forward_b = fwd_select(rs2_in, ctrl_q.regwrite, wr_q, mem_wb_regwrite, mem_wb_rd);
`else
    logic fwd_unused;
    assign fwd_unused = ^{mem_wb_rd, mem_wb_regwrite};
    assign forward_a  = FWD_REG;
    assign forward_b  = FWD_REG;
`endif

    assign op_a  = fwd_mux(forward_a, rd1_in, wb_data, alu_res_q);
    assign rd2_d = fwd_mux(forward_b, rd2_in, wb_data, alu_res_q);
    assign op_b  = alusrc_in ? imm_in : rd2_d;
    assign pc_d  = pc_in + imm_in;

    assign ctrl_d = '{branch:   branch_in,
                      memwrite: memwrite_in,
                      memread:  memread_in,
                      memtoreg: memtoreg_in,
                      regwrite: regwrite_in};

    alu_core u_alu (
        .a      (op_a),
        .b      (op_b),
        .op     (alu_control_signal),
        .result (alu_res_d),
        .zero   (zero_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= '0;
            zero_q    <= 1'b0;
            alu_res_q <= '0;
            rd2_q     <= '0;
            wr_q      <= '0;
            ctrl_q    <= '0;
        end else begin
            pc_q      <= pc_d;
            zero_q    <= zero_d;
            alu_res_q <= alu_res_d;
            rd2_q     <= rd2_d;
            wr_q      <= write_reg_in;
            // A flush turns the instruction into a bubble but keeps its data.
            ctrl_q    <= flush ? '0 : ctrl_d;
        end
    end

    assign pc_out         = pc_q;
    assign zero_out       = zero_q;
    assign alu_result_out = alu_res_q;
    assign read_data2_out = rd2_q;
    assign write_reg_out  = wr_q;
    assign branch_out     = ctrl_q.branch;
    assign memwrite_out   = ctrl_q.memwrite;
    assign memread_out    = ctrl_q.memread;
    assign memtoreg_out   = ctrl_q.memtoreg;
    assign regwrite_out   = ctrl_q.regwrite;
endmodule

// File: tb/tb_ex_mem_reg.sv
// Bench for ex_mem_reg: directed table, hand sequences for reset/flush, then random
// traffic against a behavioural model. Expectations follow EX_FORWARDING_EN.
module tb_ex_mem_reg;

`ifdef EX_FORWARDING_EN
    localparam bit FWD_ON = 1'b1;
`else
    localparam bit FWD_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ex_mem_reg_if bus();

    ex_mem_reg dut (
        .clk(clk), .rst(rst), .flush(bus.flush),
        .alu_control_signal(bus.alu_control_signal),
        .pc_in(bus.pc_in), .imm_in(bus.imm_in), .alusrc_in(bus.alusrc_in),
        .rs1_in(bus.rs1_in), .rs2_in(bus.rs2_in), .rd1_in(bus.rd1_in), .rd2_in(bus.rd2_in),
        .write_reg_in(bus.write_reg_in), .branch_in(bus.branch_in),
        .memwrite_in(bus.memwrite_in), .memread_in(bus.memread_in),
        .memtoreg_in(bus.memtoreg_in), .regwrite_in(bus.regwrite_in),
        .mem_wb_rd(bus.mem_wb_rd), .mem_wb_regwrite(bus.mem_wb_regwrite),
        .wb_data(bus.wb_data), .pc_out(bus.pc_out), .zero_out(bus.zero_out),
        .alu_result_out(bus.alu_result_out), .read_data2_out(bus.read_data2_out),
        .write_reg_out(bus.write_reg_out), .branch_out(bus.branch_out),
        .memwrite_out(bus.memwrite_out), .memread_out(bus.memread_out),
        .memtoreg_out(bus.memtoreg_out), .regwrite_out(bus.regwrite_out),
        .forward_a(bus.forward_a), .forward_b(bus.forward_b)
    );

    // ctrl = {branch, memwrite, memread, memtoreg, regwrite}
    typedef struct {
        bit          rst;
        bit          flush;
        logic [3:0]  op;
        logic [63:0] pc, imm, rd1, rd2, wb;
        logic        alusrc;
        logic [4:0]  rs1, rs2, wr, mwrd;
        logic        mwrw;
        logic [4:0]  ctrl;
    } in_t;

    typedef struct {
        in_t         i;
        logic [63:0] res_on, res_off, rd2o_on, rd2o_off, pc_o;
        logic        zero, rw;
        logic [1:0]  fa_on, fb_on;
    } row_t;

    int n_vec = 0;
    int n_chk = 0;
    int n_err = 0;

    // Model of what the stage has latched (the previous instruction's outcome).
    logic [63:0] m_pc = '0, m_res = '0, m_rd2 = '0;
    logic        m_zero = 1'b0;
    logic [4:0]  m_wr = '0, m_ctrl = '0;

    function automatic in_t mk(bit r, bit f, logic [3:0] op, logic [63:0] pc, logic [63:0] imm,
                               logic alusrc, logic [4:0] rs1, logic [4:0] rs2,
                               logic [63:0] rd1, logic [63:0] rd2, logic [4:0] wr,
                               logic [4:0] ctrl, logic [4:0] mwrd, logic mwrw, logic [63:0] wb);
        in_t v;
        v.rst = r; v.flush = f; v.op = op; v.pc = pc; v.imm = imm; v.alusrc = alusrc;
        v.rs1 = rs1; v.rs2 = rs2; v.rd1 = rd1; v.rd2 = rd2; v.wr = wr; v.ctrl = ctrl;
        v.mwrd = mwrd; v.mwrw = mwrw; v.wb = wb;
        return v;
    endfunction

    function automatic logic [63:0] alu_ref(logic [3:0] op, logic [63:0] a, logic [63:0] b);
        int sh;
        sh = int'(b % 64);
        case (op)
            4'd0: return a & b;
            4'd1: return a | b;
            4'd2: return a + b;
            4'd3: return a ^ b;
            4'd4: return a << sh;
            4'd5: return a >> sh;
            4'd6: return a - b;
            4'd7: return (longint'(a) < longint'(b)) ? 64'd1 : 64'd0;
            default: return 64'd0;
        endcase
    endfunction

    // Which source supplies a register operand: 2 = last result, 1 = writeback, 0 = file.
    function automatic logic [1:0] ref_src(logic [4:0] rs, in_t v);
        if (!FWD_ON || rs == 5'd0) return 2'd0;
        if (m_ctrl[0] && m_wr == rs) return 2'd2;
        if (v.mwrw && v.mwrd == rs) return 2'd1;
        return 2'd0;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (vector %0d)", nm, act, exp, n_vec);
        end
    endtask

    task automatic drive(input in_t v);
        rst                    = v.rst;
        bus.flush              = v.flush;
        bus.alu_control_signal = v.op;
        bus.pc_in              = v.pc;
        bus.imm_in             = v.imm;
        bus.alusrc_in          = v.alusrc;
        bus.rs1_in             = v.rs1;
        bus.rs2_in             = v.rs2;
        bus.rd1_in             = v.rd1;
        bus.rd2_in             = v.rd2;
        bus.write_reg_in       = v.wr;
        {bus.branch_in, bus.memwrite_in, bus.memread_in, bus.memtoreg_in, bus.regwrite_in} = v.ctrl;
        bus.mem_wb_rd          = v.mwrd;
        bus.mem_wb_regwrite    = v.mwrw;
        bus.wb_data            = v.wb;
    endtask

    task automatic apply(input in_t v, output logic [1:0] fa, output logic [1:0] fb);
        logic [1:0]  sa, sb;
        logic [63:0] a, b, bm;
        @(negedge clk);
        drive(v);
        #1;
        sa = ref_src(v.rs1, v);
        sb = ref_src(v.rs2, v);
        fa = bus.forward_a;
        fb = bus.forward_b;
        chk("forward_a", {62'd0, fa}, {62'd0, sa});
        chk("forward_b", {62'd0, fb}, {62'd0, sb});
        a  = (sa == 2'd2) ? m_res : (sa == 2'd1) ? v.wb : v.rd1;
        b  = (sb == 2'd2) ? m_res : (sb == 2'd1) ? v.wb : v.rd2;
        bm = v.alusrc ? v.imm : b;
        @(posedge clk);
        if (v.rst) begin
            m_pc = '0; m_res = '0; m_rd2 = '0; m_zero = 1'b0; m_wr = '0; m_ctrl = '0;
        end else begin
            m_res  = alu_ref(v.op, a, bm);
            m_zero = (m_res == 64'd0);
            m_pc   = v.pc + v.imm;
            m_rd2  = b;
            m_wr   = v.wr;
            m_ctrl = v.flush ? 5'd0 : v.ctrl;
        end
        #1;
        chk("pc_out", bus.pc_out, m_pc);
        chk("zero_out", {63'd0, bus.zero_out}, {63'd0, m_zero});
        chk("alu_result_out", bus.alu_result_out, m_res);
        chk("read_data2_out", bus.read_data2_out, m_rd2);
        chk("write_reg_out", {59'd0, bus.write_reg_out}, {59'd0, m_wr});
        chk("ctrl_out", {59'd0, bus.branch_out, bus.memwrite_out, bus.memread_out,
                         bus.memtoreg_out, bus.regwrite_out}, {59'd0, m_ctrl});
        $display("vec %0d rst=%0b fl=%0b op=%0d fa=%0d fb=%0d res=%h zero=%0b",
                 n_vec, v.rst, v.flush, v.op, fa, fb, bus.alu_result_out, bus.zero_out);
        n_vec++;
    endtask

    row_t        tbl[6];
    in_t         v;
    logic [1:0]  fa, fb;

    initial begin
        // {rst,flush,op,pc,imm,alusrc,rs1,rs2,rd1,rd2,wr,ctrl,mwrd,mwrw,wb}
        tbl[0].i = mk(0,0,4'd2,64'h100,64'h8,0,5'd1,5'd2,64'd5,64'd10,5'd5,5'b00001,5'd0,0,64'd0);
        tbl[0].res_on = 64'd15; tbl[0].res_off = 64'd15; tbl[0].rd2o_on = 64'd10; tbl[0].rd2o_off = 64'd10;
        tbl[0].pc_o = 64'h108; tbl[0].zero = 0; tbl[0].rw = 1; tbl[0].fa_on = 2'b00; tbl[0].fb_on = 2'b00;
        tbl[1].i = mk(0,0,4'd2,64'h200,64'h0,0,5'd5,5'd3,64'd99,64'd1,5'd14,5'b00001,5'd0,0,64'd0);
        tbl[1].res_on = 64'd16; tbl[1].res_off = 64'd100; tbl[1].rd2o_on = 64'd1; tbl[1].rd2o_off = 64'd1;
        tbl[1].pc_o = 64'h200; tbl[1].zero = 0; tbl[1].rw = 1; tbl[1].fa_on = 2'b10; tbl[1].fb_on = 2'b00;
        tbl[2].i = mk(0,0,4'd2,64'h300,64'h4,0,5'd0,5'd14,64'd50,64'd3,5'd0,5'b00001,5'd14,1,64'd7);
        tbl[2].res_on = 64'd66; tbl[2].res_off = 64'd53; tbl[2].rd2o_on = 64'd16; tbl[2].rd2o_off = 64'd3;
        tbl[2].pc_o = 64'h304; tbl[2].zero = 0; tbl[2].rw = 1; tbl[2].fa_on = 2'b00; tbl[2].fb_on = 2'b10;
        tbl[3].i = mk(0,0,4'd6,64'h40,64'h10,0,5'd0,5'd0,64'd12,64'd12,5'd6,5'b00001,5'd0,0,64'd0);
        tbl[3].res_on = 64'd0; tbl[3].res_off = 64'd0; tbl[3].rd2o_on = 64'd12; tbl[3].rd2o_off = 64'd12;
        tbl[3].pc_o = 64'h50; tbl[3].zero = 1; tbl[3].rw = 1; tbl[3].fa_on = 2'b00; tbl[3].fb_on = 2'b00;
        tbl[4].i = mk(0,0,4'd1,64'h60,64'h0,0,5'd9,5'd6,64'd1,64'h77,5'd7,5'b00000,5'd9,1,64'h1000);
        tbl[4].res_on = 64'h1000; tbl[4].res_off = 64'h77; tbl[4].rd2o_on = 64'd0; tbl[4].rd2o_off = 64'h77;
        tbl[4].pc_o = 64'h60; tbl[4].zero = 0; tbl[4].rw = 0; tbl[4].fa_on = 2'b01; tbl[4].fb_on = 2'b10;
        tbl[5].i = mk(0,0,4'd2,64'h1000,64'h20,1,5'd7,5'd0,64'd3,64'h55,5'd8,5'b00000,5'd0,0,64'd0);
        tbl[5].res_on = 64'h23; tbl[5].res_off = 64'h23; tbl[5].rd2o_on = 64'h55; tbl[5].rd2o_off = 64'h55;
        tbl[5].pc_o = 64'h1020; tbl[5].zero = 0; tbl[5].rw = 0; tbl[5].fa_on = 2'b00; tbl[5].fb_on = 2'b00;

        drive(mk(1,0,4'd0,0,0,0,0,0,0,0,0,5'd0,0,0,0));
        apply(mk(1,0,4'd2,64'h5,64'h5,0,5'd1,5'd1,64'd3,64'd4,5'd3,5'b11111,5'd0,0,64'd0), fa, fb);
        chk("reset_alu_result", bus.alu_result_out, 64'd0);
        chk("reset_ctrl", {59'd0, bus.branch_out, bus.memwrite_out, bus.memread_out,
                           bus.memtoreg_out, bus.regwrite_out}, 64'd0);

        for (int k = 0; k < 6; k++) begin
            apply(tbl[k].i, fa, fb);
            chk("tbl_fwd_a", {62'd0, fa}, FWD_ON ? {62'd0, tbl[k].fa_on} : 64'd0);
            chk("tbl_fwd_b", {62'd0, fb}, FWD_ON ? {62'd0, tbl[k].fb_on} : 64'd0);
            chk("tbl_result", bus.alu_result_out, FWD_ON ? tbl[k].res_on : tbl[k].res_off);
            chk("tbl_rd2", bus.read_data2_out, FWD_ON ? tbl[k].rd2o_on : tbl[k].rd2o_off);
            chk("tbl_zero", {63'd0, bus.zero_out}, {63'd0, tbl[k].zero});
            chk("tbl_pc", bus.pc_out, tbl[k].pc_o);
            chk("tbl_regwrite", {63'd0, bus.regwrite_out}, {63'd0, tbl[k].rw});
        end

        // Mid-stream reset discards the in-flight instruction.
        apply(mk(1,0,4'd2,64'h10,64'h10,0,5'd1,5'd2,64'd9,64'd9,5'd5,5'b11111,5'd0,0,64'd0), fa, fb);
        chk("rst_pc", bus.pc_out, 64'd0);
        chk("rst_wr", {59'd0, bus.write_reg_out}, 64'd0);
        chk("rst_rd2", bus.read_data2_out, 64'd0);
        // Cycle after reset: nothing to forward from EX/MEM.
        apply(mk(0,1,4'd2,64'h8,64'h8,0,5'd5,5'd5,64'd4,64'd4,5'd5,5'b11111,5'd0,0,64'd0), fa, fb);
        chk("post_rst_fwd_a", {62'd0, fa}, 64'd0);
        chk("flush_regwrite", {63'd0, bus.regwrite_out}, 64'd0);
        chk("flush_result", bus.alu_result_out, 64'd8);
        chk("flush_wr", {59'd0, bus.write_reg_out}, 64'd5);
        // Flushed bubble must not trigger forwarding of x5.
        apply(mk(1,1,4'd2,64'h8,64'h8,0,5'd5,5'd0,64'd1,64'd1,5'd5,5'b11111,5'd0,0,64'd0), fa, fb);
        chk("bubble_fwd_a", {62'd0, fa}, 64'd0);
        chk("rst_over_flush", bus.alu_result_out, 64'd0);

        for (int k = 0; k < 400; k++) begin
            v = mk(($urandom_range(0, 19) == 0), ($urandom_range(0, 7) == 0),
                   4'($urandom_range(0, 15)), {$urandom, $urandom}, {$urandom, $urandom},
                   1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom_range(0, 7)),
                   5'($urandom), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                   {$urandom, $urandom});
            if ($urandom_range(0, 3) == 0) begin
                v.rd1 = 64'($urandom_range(0, 3));
                v.rd2 = 64'($urandom_range(0, 3)) - 64'd1;
                v.imm = 64'($urandom_range(0, 70));
            end
            apply(v, fa, fb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ex_mem_reg.md
EX_MEM_REG -- requirements
Module: ex_mem_reg

Interface
REQ-001 Ports SHALL be (name direction width meaning):
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  bubble insert; zeroes captured control bits.
- alu_control_signal  in  4  ALU operation code.
- pc_in  in  64  ID/EX PC.
- imm_in  in  64  sign-extended byte offset / immediate.
- alusrc_in  in  1  1 = ALU operand B is imm_in.
- rs1_in, rs2_in  in  5 each  ID/EX source register numbers.
- rd1_in, rd2_in  in  64 each  ID/EX register read data.
- write_reg_in  in  5  destination register.
- branch_in, memwrite_in, memread_in, memtoreg_in, regwrite_in  in  1 each  control bits.
- mem_wb_rd  in  5  MEM/WB destination register.
- mem_wb_regwrite  in  1  MEM/WB write enable.
- wb_data  in  64  MEM/WB writeback value.
- pc_out  out  64  registered branch target.
- zero_out  out  1  registered ALU-zero flag.
- alu_result_out  out  64  registered ALU result.
- read_data2_out  out  64  registered store data.
- write_reg_out  out  5  registered destination register.
- branch_out, memwrite_out, memread_out, memtoreg_out, regwrite_out  out  1 each  registered control bits.
- forward_a, forward_b  out  2 each  combinational forwarding selects.

Function
REQ-002 Forward select encoding SHALL be: 00 = ID/EX register value, 01 = wb_data, 10 = alu_result_out.
REQ-003 forward_a SHALL be 10 when regwrite_out and write_reg_out != 0 and write_reg_out == rs1_in; else 01 when mem_wb_regwrite and mem_wb_rd != 0 and mem_wb_rd == rs1_in; else 00. forward_b SHALL use the same rule with rs2_in.
REQ-004 EX/MEM match SHALL take priority over MEM/WB match when both hit.
REQ-005 Register x0 SHALL never be forwarded; forward_a and forward_b SHALL be 00 when the source register is 0.
REQ-006 Forwarded A SHALL feed ALU operand A. Forwarded B SHALL feed the alusrc mux, which selects imm_in when alusrc_in = 1.
REQ-007 read_data2_out SHALL capture the forwarded B value, taken before the alusrc mux.
REQ-008 ALU codes SHALL be: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SLL, 0101 SRL, 0110 SUB, 0111 SLT (signed, result 0 or 1).
REQ-009 Undefined ALU codes SHALL produce 0.
REQ-010 ALU arithmetic SHALL be 64-bit with wrap-around; no overflow flag.
REQ-011 Shift amounts SHALL use operand B bits [5:0] only.
REQ-012 zero SHALL be 1 exactly when the ALU result is all zeros.
REQ-013 Branch target SHALL be pc_in + imm_in, 64-bit with wrap-around, captured into pc_out.
REQ-014 On each posedge without rst, all *_out registers SHALL capture their EX values, with 1-cycle latency.
REQ-015 Forwarding SHALL use the current (pre-edge) register outputs.
REQ-016 With flush = 1 and rst = 0, the five control bits SHALL capture 0; data fields SHALL capture normally.

Reset
REQ-017 While rst is high at posedge, every registered output SHALL become 0: pc_out, zero_out, alu_result_out, read_data2_out, write_reg_out and all control bits.
REQ-018 Reset SHALL take priority over flush.
REQ-019 Reset SHALL discard any in-flight EX result.
REQ-020 forward_a and forward_b SHALL evaluate to 00 in the cycle after reset, unless MEM/WB matches.

Configuration
REQ-021 Macro EX_FORWARDING_EN defined: forwarding SHALL behave per REQ-003 to REQ-005.
REQ-022 Macro EX_FORWARDING_EN undefined: forward_a and forward_b SHALL be tied to 00, and operands SHALL come only from rd1_in and rd2_in.

Structure
REQ-023 Shared package ex_pkg SHALL hold the ALU opcode constants and the forward-select constants (FWD_REG, FWD_WB, FWD_EXMEM).
REQ-024 The ALU SHALL be the sub-module alu_core (combinational: a, b, op -> result, zero). Forwarding logic and pipeline registers SHALL stay in ex_mem_reg.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- ADD, rd1 = 5, rd2 = 10, alusrc = 0 -> alu_result_out = 15, zero_out = 0, one cycle later.
- SUB, rd1 = 12, rd2 = 12 -> alu_result_out = 0, zero_out = 1; pc_in = 0x40, imm_in = 0x10 -> pc_out = 0x50.
- Back-to-back dependency: prior write_reg_out = 5, regwrite_out = 1, result 15; rs1_in = 5 -> forward_a = 10, operand A = 15.
- Double hazard: EX/MEM and MEM/WB both target x14, rs2_in = 14 -> forward_b = 10.
- rd = 0: EX/MEM write to x0 with rs1_in = 0 -> forward_a = 00.
- Reset and flush: rst high mid-stream -> all outputs 0 next edge; then flush = 1 with regwrite_in = 1 -> regwrite_out = 0 while alu_result_out updates.
